sample_writer: RTL

SAMPLE_WRITER -- requirements
Module: sample_writer

---
 rtl/sample_writer_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 60 ++++++
 rtl/sample_writer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sample_writer_pkg.sv
// Types shared by the sample writer: bus FSM state encoding and the two-sample word layout.
package sample_writer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam int SMP_W = 16;

    // First sample lands in the low half, second sample in the high half.
    typedef struct packed {
        logic [SMP_W-1:0] upper;
        logic [SMP_W-1:0] lower;
    } packed_word_t;

    function automatic packed_word_t pack_word(input logic [SMP_W-1:0] first,
                                               input logic [SMP_W-1:0] second);
        packed_word_t w;
        w.lower = first;
        w.upper = second;
        return w;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous word FIFO with registered occupancy count; head word is visible on rdata.
module sample_fifo
    import sample_writer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Push is judged against occupancy before any same-cycle pop.
    assign do_push = push && (count != DEPTH_C) && !clear;
    assign do_pop  = pop && (count != '0) && !clear;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sample_writer.sv
// Packs sample pairs into words, queues them, and writes them into a ring buffer over Wishbone.
module sample_writer
    import sample_writer_pkg::*;
#(
    parameter int DAT_WIDTH  = 32,
    parameter int ADR_WIDTH  = 13,
    parameter int SMP_WIDTH  = 16,
    parameter int RING_WORDS = 2048,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 nReset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 sampleValid,
    input  logic [SMP_WIDTH-1:0] sampleData,
    output logic                 sampleReady,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    output logic [3:0]           sel_o,
    output logic                 we_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    output logic [ADR_WIDTH-3:0] writePointer,
    output logic                 wrapped,
    output logic                 overflow,
    output logic                 busError
);

    localparam int PTR_W = ADR_WIDTH - 2;
    localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(RING_WORDS - 1);

    state_t               state;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 start;
    logic                 done;
    logic                 advance;
    logic                 half_valid;
    logic [SMP_WIDTH-1:0] half_data;
    logic [DAT_WIDTH-1:0] head;
    logic [DAT_WIDTH-1:0] word;

    assign sampleReady = !fifo_full;
    assign accept      = sampleValid && sampleReady && !clear;
    assign push        = accept && half_valid;
    assign word        = {sampleData, half_data};
    assign start       = (state == IDLE) && enable && !fifo_empty && !clear;
    assign done        = (state == BUS) && (ack_i || err_i || rty_i);
    // err outranks rty, rty outranks ack; only a retry keeps the word queued.
    assign advance     = done && !clear && (err_i || (!rty_i && ack_i));
    assign pop         = advance;

    sample_fifo #(
        .WIDTH (DAT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .nReset (nReset),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wdata  (word),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            half_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            half_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) half_valid <= !half_valid;
            if (sampleValid && !sampleReady) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !half_valid) half_data <= sampleData;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= 4'h0;
            adr_o <= '0;
            dat_o <= '0;
        end else if (clear) begin
            state <= IDLE;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUS;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        sel_o <= 4'hF;
                        dat_o <= head;
                        adr_o <= {writePointer, 2'b00};
                    end
                end
                BUS: begin
                    if (done) begin
                        state <= IDLE;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        sel_o <= 4'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            writePointer <= '0;
            wrapped      <= 1'b0;
            busError     <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (clear) begin
                writePointer <= '0;
                busError     <= 1'b0;
            end else if (advance) begin
                writePointer <= (writePointer == LAST_WORD) ? '0 : writePointer + 1'b1;
                wrapped      <= (writePointer == LAST_WORD);
                if (err_i) busError <= 1'b1;
            end
        end
    end

endmodule
